seq_detector_param: RTL and testbench

//  Parametrised serial bit-pattern detector, successor of the fixed 1101 Mealy

---
 rtl/seq_detector_param.sv | 99 +++++++++
 tb/tb_seq_detector_param.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// -----------------------------------------------------------------------------
// seq_detector_param
//   Serial bit-pattern detector for a 1-bit stream. It matches a LEN-bit
//   PATTERN. PATTERN[LEN-1] is the oldest bit and PATTERN[0] is the newest.
//   A match is reported with a zero-latency Mealy pulse in the same cycle as
//   the final pattern bit. A saturating counter counts the matches.
//   OVERLAP selects whether the pattern suffix can start the next match.
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        synchronous active-high reset
//   clr_i        synchronous clear, same effect as rst_i
//   in_valid_i   qualifies in_i; unqualified bits are ignored
//   in_i         serial data bit
//   out_o        match pulse, combinational from in_i / in_valid_i
//   match_cnt_o  matches since reset/clear, saturates at all-ones
//   fill_o       number of valid history bits held, 0..LEN-1
// -----------------------------------------------------------------------------
module seq_detector_param #(
  parameter int unsigned      LEN     = 4,
  parameter logic [LEN-1:0]   PATTERN = 4'b1101,
  parameter bit               OVERLAP = 1'b0,
  parameter int unsigned      CNT_W   = 8,
  localparam int unsigned     FILL_W  = $clog2(LEN + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              in_valid_i,
  input  logic              in_i,
  output logic              out_o,
  output logic [CNT_W-1:0]  match_cnt_o,
  output logic [FILL_W-1:0] fill_o
);

  if ((LEN < 2) || (LEN > 32)) begin : g_len_check
    $error("seq_detector_param: LEN must be in the range 2..32");
  end

  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  logic [LEN-2:0]    hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0]  cnt_q,  cnt_d;
  logic [LEN-1:0]    cand_s;
  logic              full_s;
  logic              match_s;

  // Match decode and next-state computation for history, fill and counter.
  always_comb begin
    cand_s  = {hist_q, in_i};
    full_s  = (fill_q == FILL_MAX);
    // rst/clr gate the pulse so a pattern straddling a reset never reports.
    match_s = in_valid_i & ~rst_i & ~clr_i & full_s & (cand_s == PATTERN);
    hist_d  = hist_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    if (in_valid_i) begin
      if (match_s && !OVERLAP) begin
        // In non-overlapping mode, the next match needs LEN fresh bits.
        hist_d = '0;
        fill_d = '0;
      end else begin
        // The low LEN-1 bits of the candidate are the shifted history.
        // This form also works for LEN=2.
        hist_d = cand_s[LEN-2:0];
        fill_d = full_s ? FILL_MAX : (fill_q + FILL_W'(1));
      end
      if (match_s && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      hist_d = hist_q;
      fill_d = fill_q;
      cnt_d  = cnt_q;
    end
  end

  // State registers with synchronous reset/clear.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      hist_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_o       = match_s;
  assign match_cnt_o = cnt_q;
  assign fill_o      = fill_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// -----------------------------------------------------------------------------
// tb_seq_detector_param
//   Three detector instances share one input stream:
//     u_ov : LEN=4, 1101, overlapping
//     u_no : LEN=4, 1101, non-overlapping
//     u_l2 : LEN=2, 11, overlapping, 2-bit saturating counter
//   The bench applies a table of hand-computed vectors to u_ov and u_no.
//   A hand-written sequence covers LEN=2 saturation and clear. A random
//   stream follows. A behavioural model checks every instance on every cycle.
// -----------------------------------------------------------------------------
module tb_seq_detector_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  logic vld = 1'b0;
  logic din = 1'b0;

  logic       out_ov, out_no, out_l2;
  logic [7:0] cnt_ov, cnt_no;
  logic [1:0] cnt_l2;
  logic [2:0] fill_ov, fill_no;
  logic [1:0] fill_l2;

  always #5 clk = ~clk;

  seq_detector_param #(.LEN(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CNT_W(8)) u_ov (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .in_valid_i(vld), .in_i(din),
    .out_o(out_ov), .match_cnt_o(cnt_ov), .fill_o(fill_ov));

  seq_detector_param #(.LEN(4), .PATTERN(4'b1101), .OVERLAP(1'b0), .CNT_W(8)) u_no (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .in_valid_i(vld), .in_i(din),
    .out_o(out_no), .match_cnt_o(cnt_no), .fill_o(fill_no));

  seq_detector_param #(.LEN(2), .PATTERN(2'b11), .OVERLAP(1'b1), .CNT_W(2)) u_l2 (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .in_valid_i(vld), .in_i(din),
    .out_o(out_l2), .match_cnt_o(cnt_l2), .fill_o(fill_l2));

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state, one slot per instance: ov, no, l2.
  int          m_len [3] = '{4, 4, 2};
  logic [31:0] m_pat [3] = '{32'd13, 32'd13, 32'd3};
  bit          m_ovl [3] = '{1'b1, 1'b0, 1'b1};
  int          m_max [3] = '{255, 255, 3};
  int          m_n   [3] = '{0, 0, 0};
  logic [31:0] m_sh  [3] = '{32'd0, 32'd0, 32'd0};
  int          m_cnt [3] = '{0, 0, 0};

  typedef struct {
    logic r, c, v, d;
    logic eo_ov, eo_no;
    int   ec_ov, ec_no;
    int   ef_ov, ef_no;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic model_out(input int i, input logic r, input logic c,
                                     input logic v, input logic d);
    logic [63:0] cand;
    logic [63:0] mask;
    cand = 64'({m_sh[i], d});
    mask = (64'd1 << m_len[i]) - 64'd1;
    return !r && !c && v && (m_n[i] >= m_len[i] - 1) &&
           ((cand & mask) == (64'(m_pat[i]) & mask));
  endfunction

  function automatic int model_fill(input int i);
    return (m_n[i] < m_len[i] - 1) ? m_n[i] : m_len[i] - 1;
  endfunction

  // One cycle: drive, check the Mealy outputs before the edge, then check
  // the registered state after the edge against the model.
  task automatic step(input logic r, input logic c, input logic v, input logic d,
                      output logic [2:0] o);
    logic eo [3];
    @(negedge clk);
    rst = r; clr = c; vld = v; din = d;
    #1;
    o = {out_l2, out_no, out_ov};
    for (int i = 0; i < 3; i++) eo[i] = model_out(i, r, c, v, d);
    chk("model_out_ov", int'(out_ov), int'(eo[0]));
    chk("model_out_no", int'(out_no), int'(eo[1]));
    chk("model_out_l2", int'(out_l2), int'(eo[2]));
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (r || c) begin
        m_n[i] = 0; m_sh[i] = 32'd0; m_cnt[i] = 0;
      end else if (v) begin
        if (eo[i] && (m_cnt[i] < m_max[i])) m_cnt[i]++;
        if (eo[i] && !m_ovl[i]) begin
          m_n[i] = 0; m_sh[i] = 32'd0;
        end else begin
          m_sh[i] = {m_sh[i][30:0], d};
          m_n[i]++;
        end
      end
    end
    chk("model_cnt_ov",  int'(cnt_ov),  m_cnt[0]);
    chk("model_cnt_no",  int'(cnt_no),  m_cnt[1]);
    chk("model_cnt_l2",  int'(cnt_l2),  m_cnt[2]);
    chk("model_fill_ov", int'(fill_ov), model_fill(0));
    chk("model_fill_no", int'(fill_no), model_fill(1));
    chk("model_fill_l2", int'(fill_l2), model_fill(2));
  endtask

  task automatic add(input logic r, c, v, d, input logic eov, eno,
                     input int cov, cno, fov, fno);
    vec_t t;
    t.r = r; t.c = c; t.v = v; t.d = d;
    t.eo_ov = eov; t.eo_no = eno;
    t.ec_ov = cov; t.ec_no = cno; t.ef_ov = fov; t.ef_no = fno;
    vecs.push_back(t);
  endtask

  initial begin
    logic [2:0] o;
    int l2_out [6] = '{0, 1, 1, 1, 1, 1};
    int l2_cnt [6] = '{0, 1, 2, 3, 3, 3};

    // Columns: rst, clr, vld, in | out_ov, out_no | cnt_ov, cnt_no | fill_ov, fill_no
    // Reset for two cycles. The first cycle would otherwise see vld=1.
    add(1,0,1,1, 0,0, 0,0, 0,0);
    add(1,0,0,0, 0,0, 0,0, 0,0);
    add(0,0,1,0, 0,0, 0,0, 1,1);
    // Stream 1,1,0,1,1,0,1: overlap matches on bits 4 and 7, non-overlap on 4.
    add(0,0,1,1, 0,0, 0,0, 2,2);
    add(0,0,1,1, 0,0, 0,0, 3,3);
    add(0,0,1,0, 0,0, 0,0, 3,3);
    add(0,0,1,1, 1,1, 1,1, 3,0);
    add(0,0,1,1, 0,0, 1,1, 3,1);
    add(0,0,1,0, 0,0, 1,1, 3,2);
    add(0,0,1,1, 1,0, 2,1, 3,3);
    // Partial 1,1,0, then rst while a completing 1 is presented.
    add(0,0,1,1, 0,0, 2,1, 3,3);
    add(0,0,1,1, 0,0, 2,1, 3,3);
    add(0,0,1,0, 0,0, 2,1, 3,3);
    add(1,0,1,1, 0,0, 0,0, 0,0);
    // After the reset, the full pattern must arrive fresh.
    add(0,0,1,1, 0,0, 0,0, 1,1);
    add(0,0,1,1, 0,0, 0,0, 2,2);
    add(0,0,1,0, 0,0, 0,0, 3,3);
    add(0,0,1,1, 1,1, 1,1, 3,0);
    // Clear, then 1,1,0,1 with three-cycle invalid gaps and a toggling input.
    add(0,1,1,1, 0,0, 0,0, 0,0);
    add(0,0,1,1, 0,0, 0,0, 1,1);
    add(0,0,0,0, 0,0, 0,0, 1,1);
    add(0,0,0,1, 0,0, 0,0, 1,1);
    add(0,0,0,0, 0,0, 0,0, 1,1);
    add(0,0,1,1, 0,0, 0,0, 2,2);
    add(0,0,0,1, 0,0, 0,0, 2,2);
    add(0,0,0,0, 0,0, 0,0, 2,2);
    add(0,0,0,1, 0,0, 0,0, 2,2);
    add(0,0,1,0, 0,0, 0,0, 3,3);
    add(0,0,0,1, 0,0, 0,0, 3,3);
    add(0,0,0,1, 0,0, 0,0, 3,3);
    add(0,0,0,1, 0,0, 0,0, 3,3);
    add(0,0,1,1, 1,1, 1,1, 3,0);

    foreach (vecs[k]) begin
      step(vecs[k].r, vecs[k].c, vecs[k].v, vecs[k].d, o);
      chk($sformatf("vec%0d_out_ov", k), int'(o[0]), int'(vecs[k].eo_ov));
      chk($sformatf("vec%0d_out_no", k), int'(o[1]), int'(vecs[k].eo_no));
      chk($sformatf("vec%0d_cnt_ov", k), int'(cnt_ov), vecs[k].ec_ov);
      chk($sformatf("vec%0d_cnt_no", k), int'(cnt_no), vecs[k].ec_no);
      chk($sformatf("vec%0d_fill_ov", k), int'(fill_ov), vecs[k].ef_ov);
      chk($sformatf("vec%0d_fill_no", k), int'(fill_no), vecs[k].ef_no);
    end

    // LEN=2, pattern 11: six 1s. Counter saturates at 3. Clear resets it.
    step(1'b0, 1'b1, 1'b1, 1'b0, o);
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, o);
      chk($sformatf("l2_bit%0d_out", k + 1), int'(o[2]), l2_out[k]);
      chk($sformatf("l2_bit%0d_cnt", k + 1), int'(cnt_l2), l2_cnt[k]);
      chk($sformatf("l2_bit%0d_fill", k + 1), int'(fill_l2), 1);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, o);
    chk("l2_clr_cnt", int'(cnt_l2), 0);
    chk("l2_clr_fill", int'(fill_l2), 0);

    // Random background stream, checked against the model only.
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 59) == 0),
           ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), o);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
